// File: rtl/shift_normalizer16_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer16_if
// Brief    : Request/result handshake bundle for the shift normalizer.
// Revision : 1.0
// ============================================================================
interface shift_normalizer16_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] A;
    logic             mode;
    logic             valid_out;
    logic             ready_out;
    logic [WIDTH-1:0] B;
    logic [CNT_W-1:0] cnt;
    logic             zero;

    modport master (
        output valid_in, A, mode, ready_out,
        input  ready_in, valid_out, B, cnt, zero
    );

    modport slave (
        input  valid_in, A, mode, ready_out,
        output ready_in, valid_out, B, cnt, zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_normalizer16.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer16
// Brief    : One-bit-per-cycle left normalizer (CLZ/CLS style) with handshakes.
// Revision : 1.0
// ============================================================================
module shift_normalizer16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    shift_normalizer16_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             mode_q, mode_d;
    logic             w_norm;

    // Signed values are normalized once the two top bits differ.
    assign w_norm = mode_q ? (b_q[WIDTH-1] ^ b_q[WIDTH-2]) : b_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    b_d     = bus.A;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                    zero_d  = (bus.A == '0);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (zero_q || w_norm || (cnt_q == CNT_MAX)) begin
                    state_d = DONE;
                end else begin
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.ready_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_in  = (state_q == IDLE);
    assign bus.valid_out = (state_q == DONE);
    assign bus.B         = b_q;
    assign bus.cnt       = cnt_q;
    assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer16.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_normalizer16
// Brief    : Scoreboard bench for shift_normalizer16 (directed + random).
// Revision : 1.0
// ============================================================================
module tb_shift_normalizer16;
    typedef struct {
        logic [15:0] a;
        logic        m;
        logic [15:0] b;
        logic [3:0]  c;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   acc_edge = 0;
    bit   rand_on = 1'b0;
    exp_t sb[$];

    shift_normalizer16_if bus ();

    shift_normalizer16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic m, input logic [15:0] b,
                        input logic [3:0] c, input logic z);
        exp_t e;
        e.a = a; e.m = m; e.b = b; e.c = c; e.z = z;
        sb.push_back(e);
    endtask

    // Independent reference: count leading zeros / redundant sign bits directly.
    function automatic exp_t model(input logic [15:0] a, input logic m);
        exp_t e;
        int   n = 0;
        e.a = a; e.m = m; e.z = (a == 16'h0000);
        if (a != 16'h0000) begin
            for (int i = 14 + (m ? 0 : 1); i >= 0; i--) begin
                if (m ? (a[i] != a[15]) : a[i]) break;
                n++;
            end
        end
        if (n > 15) n = 15;
        e.c = n[3:0];
        e.b = a << n;
        return e;
    endfunction

    task automatic send(input logic [15:0] a, input logic m);
        bit ok = 1'b0;
        @(posedge clk); #2;
        bus.valid_in = 1'b1; bus.A = a; bus.mode = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ready_in) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        #2 bus.valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.valid_out) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: samples on the falling edge, pops expectations on each valid_out rise.
    initial begin : monitor
        exp_t             e;
        bit               prev_v = 1'b0;
        logic [20:0]      held = '0;
        logic signed [15:0] sra;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.valid_in && bus.ready_in) acc_edge = edge_n + 1;
                if (bus.valid_out && !prev_v) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid_out", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("B", {16'h0, bus.B}, {16'h0, e.b});
                        check("cnt", {28'h0, bus.cnt}, {28'h0, e.c});
                        check("zero", {31'h0, bus.zero}, {31'h0, e.z});
                        check("latency", edge_n - acc_edge + 1, {28'h0, e.c} + 32'd2);
                        sra = $signed(bus.B) >>> bus.cnt;
                        check("inverse_shift", {16'h0, (e.m ? sra : (bus.B >> bus.cnt))},
                              {16'h0, e.a});
                        if (!e.z)
                            check("normalized",
                                  {31'h0, (e.m ? (bus.B[15] ^ bus.B[14]) : bus.B[15])}, 32'd1);
                    end
                    held = {bus.B, bus.cnt, bus.zero};
                end else if (bus.valid_out) begin
                    check("held_stable", {11'h0, bus.B, bus.cnt, bus.zero}, {11'h0, held});
                end
                prev_v = bus.valid_out;
            end
        end
    end

    initial begin : stall_gen
        forever begin
            @(posedge clk); #2;
            if (rand_on) bus.ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : stimulus
        logic [20:0] hold;
        logic [15:0] ra;
        logic        rm;
        exp_t        e;
        bit          seen;

        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.A = 16'h0; bus.mode = 1'b0; bus.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", {31'h0, bus.valid_out}, 32'd0);
        check("rst_B", {16'h0, bus.B}, 32'd0);
        check("rst_cnt", {28'h0, bus.cnt}, 32'd0);
        check("rst_zero", {31'h0, bus.zero}, 32'd0);
        check("rst_ready_in", {31'h0, bus.ready_in}, 32'd1);
        @(posedge clk); #2 rst_n = 1'b1;

        push(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0); send(16'h0001, 1'b0);
        push(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0); send(16'h8000, 1'b0);
        push(16'h0003, 1'b1, 16'h6000, 4'd13, 1'b0); send(16'h0003, 1'b1);
        push(16'hFFFE, 1'b1, 16'h8000, 4'd14, 1'b0); send(16'hFFFE, 1'b1);
        push(16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0); send(16'hFFFF, 1'b1);
        push(16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1); send(16'h0000, 1'b0);
        push(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1); send(16'h0000, 1'b1);
        push(16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0); send(16'h4000, 1'b1);
        wait_idle();

        // Consumer stall: result must stay frozen with no new accept.
        @(posedge clk); #2 bus.ready_out = 1'b0;
        push(16'h1234, 1'b0, 16'h91A0, 4'd3, 1'b0); send(16'h1234, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_out) begin seen = 1'b1; break; end
        end
        check("stall_valid_seen", {31'h0, seen}, 32'd1);
        hold = {bus.B, bus.cnt, bus.zero};
        repeat (3) begin
            @(negedge clk);
            check("stall_valid_out", {31'h0, bus.valid_out}, 32'd1);
            check("stall_ready_in", {31'h0, bus.ready_in}, 32'd0);
            check("stall_outputs", {11'h0, bus.B, bus.cnt, bus.zero}, {11'h0, hold});
        end
        @(posedge clk); #2 bus.ready_out = 1'b1;
        wait_idle();

        // Reset while shifting: the in-flight request is dropped.
        send(16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid_out", {31'h0, bus.valid_out}, 32'd0);
        check("midrst_B", {16'h0, bus.B}, 32'd0);
        check("midrst_cnt", {28'h0, bus.cnt}, 32'd0);
        check("midrst_ready_in", {31'h0, bus.ready_in}, 32'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        push(16'h4000, 1'b0, 16'h8000, 4'd1, 1'b0); send(16'h4000, 1'b0);
        wait_idle();

        // Random back-to-back traffic with random consumer stalls.
        rand_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            if (i % 6 == 5) ra = ra >> $urandom_range(6, 15);
            rm = 1'($urandom_range(0, 1));
            e = model(ra, rm);
            push(e.a, e.m, e.b, e.c, e.z);
            send(ra, rm);
        end
        wait_idle();
        rand_on = 1'b0;
        @(posedge clk); #2 bus.ready_out = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
`default_nettype wire
